myproject_mac_pipe_signed: RTL and testbench

MYPROJECT_MAC_PIPE_SIGNED -- requirements
Module: myproject_mac_pipe_signed

---
 rtl/myproject_mac_pipe_signed.sv | 113 +++++++++++
 tb/tb_myproject_mac_pipe_signed.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mac_pipe_signed.sv
// Signed multiply-accumulate pipeline: NUM_STAGE clocks from input beat to result,
// with a global valid/ready stall and optional saturation of the accumulator/result.
module myproject_mac_pipe_signed #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 18,
  parameter int DOUT_WIDTH = 29,
  parameter int NUM_STAGE  = 3,
  parameter int SAT        = 0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         din_acc,
  input  logic                         din_valid,
  output logic                         din_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_ovf,
  output logic                         dout_valid,
  input  logic                         dout_ready
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int SW = ((DOUT_WIDTH > PW) ? DOUT_WIDTH : PW) + 1;

  logic                  adv;
  logic signed [PW-1:0]  a_ext, b_ext, prod;
  logic signed [PW-1:0]  fin_p;
  logic                  fin_acc, fin_valid;

  assign adv       = ~(dout_valid & ~dout_ready);
  assign din_ready = adv;

  assign a_ext = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
  assign prod  = a_ext * b_ext;

  // Stages 1..NUM_STAGE-1 carry the product; the last stage is the output register.
  if (NUM_STAGE == 1) begin : g_direct
    assign fin_p     = prod;
    assign fin_acc   = din_acc;
    assign fin_valid = din_valid;
  end else begin : g_pipe
    for (genvar k = 0; k < NUM_STAGE - 1; k++) begin : g_stg
      logic signed [PW-1:0] p_src, p_q;
      logic                 a_src, a_q, v_src, v_q;

      if (k == 0) begin : g_first
        assign p_src = prod;
        assign a_src = din_acc;
        assign v_src = din_valid;
      end else begin : g_next
        assign p_src = g_stg[k-1].p_q;
        assign a_src = g_stg[k-1].a_q;
        assign v_src = g_stg[k-1].v_q;
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          p_q <= '0;
          a_q <= 1'b0;
          v_q <= 1'b0;
        end else if (adv) begin
          p_q <= p_src;
          a_q <= a_src;
          v_q <= v_src;
        end
      end
    end
    assign fin_p     = g_stg[NUM_STAGE-2].p_q;
    assign fin_acc   = g_stg[NUM_STAGE-2].a_q;
    assign fin_valid = g_stg[NUM_STAGE-2].v_q;
  end

  logic signed [DOUT_WIDTH-1:0] acc_q, acc_eff, res;
  logic signed [SW-1:0]         s_acc, s_p, s;
  logic [SW-DOUT_WIDTH:0]       s_hi;
  logic                         ovf;

  // The beat leaving this edge has not yet been folded into acc_q, so forward it.
  assign acc_eff = dout_valid ? dout : acc_q;
  assign s_acc   = {{(SW-DOUT_WIDTH){acc_eff[DOUT_WIDTH-1]}}, acc_eff};
  assign s_p     = {{(SW-PW){fin_p[PW-1]}}, fin_p};

  always_comb begin
    s    = fin_acc ? (s_acc + s_p) : s_p;
    s_hi = s[SW-1:DOUT_WIDTH-1];
    ovf  = ~((&s_hi) | ~(|s_hi));
    res  = s[DOUT_WIDTH-1:0];
    if (ovf && (SAT != 0)) begin
      res = s[SW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_ovf   <= 1'b0;
      acc_q      <= '0;
    end else if (adv) begin
      dout_valid <= fin_valid;
      if (fin_valid) begin
        dout     <= res;
        dout_ovf <= ovf;
      end
      if (dout_valid) begin
        acc_q <= dout;
      end
    end
  end

endmodule

// File: tb/tb_myproject_mac_pipe_signed.sv
// Directed bench for myproject_mac_pipe_signed: wrap (SAT=0) and saturate (SAT=1)
// instances share stimulus; results are checked against hand-computed tables.
`timescale 1ns/1ps
module tb_myproject_mac_pipe_signed;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [13:0] din0 = '0;
  logic signed [17:0] din1 = '0;
  logic               din_acc = 1'b0;
  logic               din_valid = 1'b0;
  logic               dout_ready = 1'b1;
  logic               din_ready0, din_ready1;
  logic signed [28:0] dout0, dout1;
  logic               ovf0, ovf1, dval0, dval1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int d0;
    bit o0;
    int d1;
    bit o1;
  } exp_t;

  typedef struct {
    int a;
    int b;
    bit acc;
    int d0;
    bit o0;
    int d1;
    bit o1;
  } vec_t;

  exp_t q[$];

  always #5 clk = ~clk;

  myproject_mac_pipe_signed #(.SAT(0)) dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1), .din_acc(din_acc),
    .din_valid(din_valid), .din_ready(din_ready0), .dout(dout0), .dout_ovf(ovf0),
    .dout_valid(dval0), .dout_ready(dout_ready)
  );

  myproject_mac_pipe_signed #(.SAT(1)) dut1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .din0(din0), .din1(din1), .din_acc(din_acc),
    .din_valid(din_valid), .din_ready(din_ready1), .dout(dout1), .dout_ovf(ovf1),
    .dout_valid(dval1), .dout_ready(dout_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents one beat and waits (bounded) for it to be accepted.
  task automatic send(input int a, input int b, input bit acc, input exp_t e);
    bit ok;
    int n;
    din0 = 14'(a);
    din1 = 18'(b);
    din_acc = acc;
    din_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = din_ready0;
      @(posedge clk);
      n++;
    end while (!ok && n < 100);
    if (ok) q.push_back(e);
    else chk("accept_timeout", 0, 1);
    #1 din_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  logic signed [28:0] held0, held1;
  bit was_stalled = 1'b0;

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (dval0 && dout_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("dout_wrap", dout0, e.d0);
          chk("ovf_wrap", ovf0, e.o0);
          chk("dout_sat", dout1, e.d1);
          chk("ovf_sat", ovf1, e.o1);
        end
      end
      if (dval0 && !dout_ready) begin
        chk("din_ready_stall", din_ready0, 0);
        if (was_stalled) begin
          chk("hold_wrap", dout0, held0);
          chk("hold_sat", dout1, held1);
        end
        held0 = dout0;
        held1 = dout1;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
    end
  end

  vec_t tbl[14];

  initial begin
    bit stale;

    tbl[0]  = '{2, 3, 1'b0, 6, 1'b0, 6, 1'b0};
    tbl[1]  = '{4, 5, 1'b1, 26, 1'b0, 26, 1'b0};
    tbl[2]  = '{-1, 6, 1'b1, 20, 1'b0, 20, 1'b0};
    tbl[3]  = '{-5, -7, 1'b1, 55, 1'b0, 55, 1'b0};
    tbl[4]  = '{-8192, -131072, 1'b0, 0, 1'b1, 268435455, 1'b1};
    tbl[5]  = '{1, 1, 1'b1, 1, 1'b0, 268435455, 1'b1};
    tbl[6]  = '{-8192, 131071, 1'b0, 8192, 1'b1, -268435456, 1'b1};
    tbl[7]  = '{8191, 131071, 1'b0, -139263, 1'b1, 268435455, 1'b1};
    tbl[8]  = '{8191, 32768, 1'b0, 268402688, 1'b0, 268402688, 1'b0};
    tbl[9]  = '{1, 32767, 1'b1, 268435455, 1'b0, 268435455, 1'b0};
    tbl[10] = '{1, 1, 1'b1, -268435456, 1'b1, 268435455, 1'b1};
    tbl[11] = '{-1, 1, 1'b1, 268435455, 1'b1, 268435454, 1'b0};
    tbl[12] = '{-8192, 32768, 1'b0, -268435456, 1'b0, -268435456, 1'b0};
    tbl[13] = '{-1, 1, 1'b1, 268435455, 1'b1, -268435456, 1'b1};

    // Reset state
    #12;
    chk("rst_dout_valid", dval0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_din_ready", din_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    // Latency: accepted at edge t, valid from edge t+2
    #1;
    din0 = 14'(100);
    din1 = -18'sd3;
    din_acc = 1'b0;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
    @(negedge clk);
    chk("lat_t0_valid", dval0, 0);
    @(negedge clk);
    chk("lat_t1_valid", dval0, 0);
    @(negedge clk);
    chk("lat_t2_valid", dval0, 1);
    chk("lat_dout", dout0, -300);
    chk("lat_ovf", ovf0, 0);
    @(negedge clk);
    chk("lat_t3_valid", dval0, 0);

    // Back-to-back table stream
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].acc, '{tbl[i].d0, tbl[i].o0, tbl[i].d1, tbl[i].o1});
    end
    drain("table_drain");

    // Downstream stall for 5 cycles during streaming
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          send(i, 10, 1'b0, '{10 * i, 1'b0, 10 * i, 1'b0});
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 dout_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 dout_ready = 1'b1;
      end
    join
    drain("stall_drain");

    // Reset with three beats in flight
    @(posedge clk);
    #1;
    send(1, 2, 1'b0, '{2, 1'b0, 2, 1'b0});
    send(3, 4, 1'b0, '{12, 1'b0, 12, 1'b0});
    send(5, 6, 1'b0, '{30, 1'b0, 30, 1'b0});
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", dval0, 0);
    chk("midrst_dout", dout0, 0);
    chk("midrst_din_ready", din_ready0, 1);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dval0 || dval1) stale = 1'b1;
    end
    chk("no_stale_output", stale, 0);
    @(posedge clk);
    #1;
    send(7, 7, 1'b1, '{49, 1'b0, 49, 1'b0});
    drain("post_reset_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
